// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its read-side executor:
// opcode / operand / address / instruction word layouts, the signed result
// type produced by the ALU, and the reader FSM state encoding.
// -----------------------------------------------------------------------------
package instr_register_pkg;

    localparam int NUM_ENTRIES = 32;
    localparam int ADDR_W      = 5;
    localparam int RES_W       = 64;

    // 4-bit opcode field; encodings 8..15 are unused and execute as "result 0".
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0]       operand_t;
    typedef logic [ADDR_W-1:0]        address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RES_W-1:0]  result_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_FIN
    } reader_state_t;

endpackage

// File: rtl/instr_alu.sv
// -----------------------------------------------------------------------------
// instr_alu
// Purely combinational 64-bit ALU for one instruction.
// Ports:
//   opc          in   opcode_t   operation select
//   op_a, op_b   in   operand_t  signed 32-bit operands
//   result       out  result_t   signed result, operands sign-extended first
//   div_by_zero  out  1          DIV/MOD with op_b == 0 (result forced to 0)
// -----------------------------------------------------------------------------
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  result,
    output logic     div_by_zero
);

    // Working in the full result width keeps MULT exact and makes
    // -2^31 / -1 representable instead of overflowing.
    result_t a_ext;
    result_t b_ext;

    assign a_ext = result_t'({{(RES_W-32){op_a[31]}}, op_a});
    assign b_ext = result_t'({{(RES_W-32){op_b[31]}}, op_b});

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            // Signed / and % truncate toward zero; remainder takes the sign of a.
            DIV: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result = a_ext / b_ext;
            end
            MOD: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// -----------------------------------------------------------------------------
// instr_exec_reader
// Walks read_pointer over a window of instruction-register entries, registers
// each instruction word, executes it in instr_alu and presents the result as a
// valid/ready beat.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   start              1-cycle request, honoured only while idle
//   first_ptr, count   window start entry and length (0 = none, clipped to 32)
//   read_pointer       registered address into the instruction register
//   instruction_word   combinational read data for read_pointer
//   res_valid/ready    result handshake
//   result, res_opcode, res_ptr, div_by_zero   beat payload
//   busy               high while a window is in progress
//   done               1-cycle pulse after the window finishes
// -----------------------------------------------------------------------------
module instr_exec_reader
    import instr_register_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_ptr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] read_pointer,
    input  instruction_t      instruction_word,
    output logic              res_valid,
    input  logic              res_ready,
    output result_t           result,
    output opcode_t           res_opcode,
    output logic [ADDR_W-1:0] res_ptr,
    output logic              div_by_zero,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_ENTRIES);

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    instruction_t      instr_q, instr_d;
    logic              valid_q, valid_d;
    result_t           result_q, result_d;
    opcode_t           opc_q, opc_d;
    logic [ADDR_W-1:0] res_ptr_q, res_ptr_d;
    logic              dbz_q, dbz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    result_t           alu_result;
    logic              alu_dbz;

    // The ALU only ever sees the registered instruction, so an X on the
    // combinational read data never reaches the outputs.
    instr_alu u_alu (
        .opc         (instr_q.opc),
        .op_a        (instr_q.op_a),
        .op_b        (instr_q.op_b),
        .result      (alu_result),
        .div_by_zero (alu_dbz)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        result_d    = result_q;
        opc_d       = opc_q;
        res_ptr_d   = res_ptr_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // busy drops the cycle after the done pulse.
        if (done_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
                    if (count == '0) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d   = first_ptr;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                instr_d = instruction_word;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d  = alu_result;
                dbz_d     = alu_dbz;
                opc_d     = instr_q.opc;
                res_ptr_d = ptr_q;
                valid_d   = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                // Payload registers simply hold until the beat is taken.
                if (valid_q && res_ready) begin
                    valid_d     = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    // Pointer width equals log2 of the depth, so +1 wraps 31 -> 0.
                    ptr_d       = ptr_q + 1'b1;
                    state_d     = (remaining_q > 1) ? S_FETCH : S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            opc_q       <= ZERO;
            res_ptr_q   <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            opc_q       <= opc_d;
            res_ptr_q   <= res_ptr_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign read_pointer = ptr_q;
    assign res_valid    = valid_q;
    assign result       = result_q;
    assign res_opcode   = opc_q;
    assign res_ptr      = res_ptr_q;
    assign div_by_zero  = dbz_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
